demux_slot_sched: RTL

DEMUX_SLOT_SCHED -- requirements
Module: demux_slot_sched

---
 rtl/demux_slot_sched_pkg.sv | 29 ++
 rtl/demux_slot_sched_demux1x8.sv | 18 +
 rtl/demux_slot_sched_next_ch_find.sv | 31 +++
 rtl/demux_slot_sched.sv | 127 ++++++++++++
 4 files changed

// File: rtl/demux_slot_sched_pkg.sv
// -----------------------------------------------------------------------------
// demux_slot_sched_pkg
// Shared types and constants for the slot-scheduled 1x8 demultiplexer.
//   state_e    : scheduler FSM states (IDLE, SCAN)
//   NUM_CH     : number of demux channels
//   SEL_W      : width of a channel index
//   lowest_set : index of the lowest set bit of a channel mask (0 if none)
// -----------------------------------------------------------------------------
package demux_slot_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m[k]) idx = SEL_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_slot_sched_demux1x8.sv
// -----------------------------------------------------------------------------
// demux1x8
// Plain 1-to-8 demultiplexer: the input bit appears on output sel_i.
//   din_i : data input
//   sel_i : output select
//   y_o   : one-hot-positioned copy of din_i, all other bits 0
// -----------------------------------------------------------------------------
module demux1x8
    import demux_slot_sched_pkg::*;
(
    input  logic              din_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [NUM_CH-1:0] y_o
);

    assign y_o = NUM_CH'(din_i) << sel_i;

endmodule

// File: rtl/demux_slot_sched_next_ch_find.sv
// -----------------------------------------------------------------------------
// next_ch_find
// Combinational search for the next enabled channel above the current one.
//   mask_i : latched channel enable mask
//   cur_i  : currently active channel
//   next_o : next set mask bit above cur_i, else the lowest set bit
//   wrap_o : 1 when no set bit lies above cur_i (the pass is complete)
// A single-bit mask always reports wrap, which is what ends a frame there.
// -----------------------------------------------------------------------------
module next_ch_find
    import demux_slot_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              wrap_o
);

    always_comb begin
        next_o = lowest_set(mask_i);
        wrap_o = 1'b1;
        // Descending walk: the last hit is the closest set bit above cur_i.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_i[k] && (k > int'(cur_i))) begin
                next_o = SEL_W'(k);
                wrap_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_slot_sched.sv
// -----------------------------------------------------------------------------
// demux_slot_sched
// Time-slot scheduler driving a 1x8 demultiplexer. After a start it visits
// every enabled channel in ascending order, dwell+1 cycles each, routing din
// to the active channel, until a stop ends the scan at a slot boundary.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a scan (accepted only in IDLE with a non-zero mask)
//   stop       : end the scan at the end of the current slot
//   en_mask    : channel enable mask, captured on an accepted start
//   dwell      : slot length minus one, captured on an accepted start
//   din        : serial data routed to the active channel
//   sel        : active channel index (holds its value in IDLE)
//   y          : demultiplexed data, zero when not scanning
//   busy       : scan running
//   frame_done : pulse on the last cycle of a complete pass
// -----------------------------------------------------------------------------
module demux_slot_sched
    import demux_slot_sched_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               din,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_CH-1:0]  y,
    output logic               busy,
    output logic               frame_done
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               stop_pend_q, stop_pend_d;

    logic [SEL_W-1:0]   next_sel;
    logic               wrap;
    logic               slot_last;
    logic               stop_seen;

    next_ch_find u_next (
        .mask_i (mask_q),
        .cur_i  (sel_q),
        .next_o (next_sel),
        .wrap_o (wrap)
    );

    // Gating din with busy keeps y at zero outside a scan.
    demux1x8 u_demux (
        .din_i (din & busy),
        .sel_i (sel_q),
        .y_o   (y)
    );

    assign busy      = (state_q == SCAN);
    assign sel       = sel_q;
    // Counter only ever runs 0..dwell_q and is cleared at the slot end,
    // so it never overflows even for dwell = all ones.
    assign slot_last = busy && (cnt_q == dwell_q);
    // A stop in the slot's final cycle still ends the scan at that boundary.
    assign stop_seen = stop | stop_pend_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        stop_pend_d = stop_pend_q;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                // A stop arriving in IDLE (including alongside start) is dropped.
                stop_pend_d = 1'b0;
                if (start && (en_mask != '0)) begin
                    mask_d  = en_mask;
                    dwell_d = dwell;
                    sel_d   = lowest_set(en_mask);
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (slot_last) begin
                    frame_done = wrap;
                    cnt_d      = '0;
                    if (stop_seen) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        sel_d = next_sel;
                    end
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    stop_pend_d = stop_seen;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            stop_pend_q <= stop_pend_d;
        end
    end

endmodule
